// File: rtl/fb_swap_pkg.sv
// Shared types and constants for the framebuffer swap controller.
package fb_swap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [31:0] FB_ADDR_DEFAULT = 32'h01E0_0000;

endpackage

// File: rtl/fb_swap_if.sv
// Valid/ready request channel carrying a new framebuffer base and its frame interval.
interface fb_swap_if;

    logic        swap_valid;
    logic        swap_ready;
    logic [31:0] swap_addr;
    logic [1:0]  swap_interval;

    modport master (
        output swap_valid,
        output swap_addr,
        output swap_interval,
        input  swap_ready
    );

    modport slave (
        input  swap_valid,
        input  swap_addr,
        input  swap_interval,
        output swap_ready
    );

endinterface

// File: rtl/fb_swap_watchdog.sv
// Counts aclk cycles spent in WAIT without a frame_start; flags expiry at TIMEOUT_CYCLES-1.
module fb_swap_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic aclk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Held at zero outside WAIT, so entering WAIT always starts from a clean count.
    always_ff @(posedge aclk) begin
        if (reset || !run || clear) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffer swap controller: applies a requested scan-out base after N frame starts.
// Optional watchdog on the WAIT state is enabled by defining FB_SWAP_TIMEOUT_EN.
module fb_swap_controller #(
    parameter logic [31:0] FB_ADDR_DEFAULT = fb_swap_pkg::FB_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
    input  logic        aclk,
    input  logic        reset,
    fb_swap_if.slave    swap,
    input  logic        frame_start,
    output logic [31:0] fb_addr,
    output logic        swap_done,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        timeout
);
    import fb_swap_pkg::*;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("fb_swap_controller: TIMEOUT_CYCLES must be >= 2");
    end

    state_t      state;
    logic [31:0] pending;
    logic [1:0]  frames_left;
    logic        handshake;
    logic        wd_expired;

    assign swap.swap_ready = (state == IDLE);
    assign busy            = (state != IDLE);
    assign handshake       = swap.swap_valid && swap.swap_ready;

    // Frame starts only count while WAITing, so a pulse in the acceptance cycle is ignored.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state       <= IDLE;
            fb_addr     <= FB_ADDR_DEFAULT;
            pending     <= '0;
            frames_left <= '0;
            swap_done   <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        pending     <= swap.swap_addr;
                        frames_left <= swap.swap_interval;
                        state       <= (swap.swap_interval == 2'd0) ? COMMIT : WAIT;
                    end
                end
                WAIT: begin
                    if (wd_expired) begin
                        state <= COMMIT;
                    end else if (frame_start) begin
                        frames_left <= frames_left - 2'd1;
                        if (frames_left == 2'd1) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    fb_addr   <= pending;
                    swap_done <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_start) begin
            frame_count <= frame_count + 16'd1;
        end
    end

`ifdef FB_SWAP_TIMEOUT_EN
    fb_swap_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .aclk    (aclk),
        .reset   (reset),
        .run     (state == WAIT),
        .clear   (frame_start),
        .expired (wd_expired)
    );

    // Sticky until reset so software can see that a swap was forced.
    always_ff @(posedge aclk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (wd_expired) begin
            timeout <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

endmodule
